// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default datapath widths and the in-flight slot record.
package fpu_pkg;

    localparam int FPU_WIDTH = 32;
    localparam int FPU_TAG_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [FPU_TAG_W-1:0] tag;
        logic                 ready;
        logic [FPU_WIDTH-1:0] data;
    } fpu_slot_t;

endpackage

// File: rtl/fpu_fwd_lookup.sv
// Single-operand priority match over the in-flight slots; the youngest
// (lowest-index) valid slot with a matching tag decides the operand.
module fpu_fwd_lookup #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic [TAG_W-1:0]       rd_tag,
    input  logic [WIDTH-1:0]       rf_data,
    input  logic [DEPTH-1:0]       slot_valid,
    input  logic [DEPTH-1:0]       slot_ready,
    input  logic [DEPTH*TAG_W-1:0] slot_tag,
    input  logic [DEPTH*WIDTH-1:0] slot_data,
    output logic [WIDTH-1:0]       src_data,
    output logic                   src_fwd,
    output logic                   pending
);

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        src_data = rf_data;
        src_fwd  = 1'b0;
        pending  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_valid[k] && (slot_tag[k*TAG_W +: TAG_W] == rd_tag)) begin
                if (slot_ready[k]) begin
                    src_data = slot_data[k*WIDTH +: WIDTH];
                    src_fwd  = 1'b1;
                    pending  = 1'b0;
                end else begin
                    src_data = rf_data;
                    src_fwd  = 1'b0;
                    pending  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpu_fwd_scoreboard.sv
// Operand-forwarding scoreboard for the FPU pipeline: shifting in-flight slots,
// per-operand forwarding, hazard detect and retire write-back.
// Optional FPU_FWD_HAZARD_CNT_EN adds a saturating 32-bit hazard cycle counter.
module fpu_fwd_scoreboard
    import fpu_pkg::*;
#(
    parameter int WIDTH  = FPU_WIDTH,
    parameter int DEPTH  = 4,
    parameter int NSRC   = 3,
    parameter int TAG_W  = FPU_TAG_W,
    parameter int SLOT_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic [TAG_W-1:0]      issue_tag,
    input  logic                  res_valid,
    input  logic [SLOT_W-1:0]     res_slot,
    input  logic [WIDTH-1:0]      res_data,
    input  logic [NSRC*TAG_W-1:0] rd_tag,
    input  logic [NSRC*WIDTH-1:0] rf_data,
    output logic [NSRC*WIDTH-1:0] src_data,
    output logic [NSRC-1:0]       src_fwd,
    output logic                  hazard,
    output logic                  retire_block,
    output logic                  wb_valid,
    output logic [TAG_W-1:0]      wb_tag,
    output logic [WIDTH-1:0]      wb_data,
    output logic                  err
`ifdef FPU_FWD_HAZARD_CNT_EN
    ,
    output logic [31:0]           hazard_cnt
`endif
);

    localparam int LAST = DEPTH - 1;

    fpu_slot_t slot_q [DEPTH];
    fpu_slot_t slot_w [DEPTH];
    fpu_slot_t slot_d [DEPTH];
    logic      err_q, err_d;

    logic [DEPTH-1:0]       wr_sel;
    logic [DEPTH-1:0]       slot_valid, slot_ready;
    logic [DEPTH*TAG_W-1:0] slot_tag;
    logic [DEPTH*WIDTH-1:0] slot_data;
    logic [NSRC-1:0]        pend;
    logic                   wr_ok, overrun;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            wr_sel[k]                    = res_valid && (res_slot == SLOT_W'(k));
            slot_valid[k]                = slot_q[k].valid;
            slot_ready[k]                = slot_q[k].ready;
            slot_tag[k*TAG_W +: TAG_W]   = TAG_W'(slot_q[k].tag);
            slot_data[k*WIDTH +: WIDTH]  = WIDTH'(slot_q[k].data);
        end
    end

    // Result writes land on the pre-shift position so they travel with the entry.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_w[k] = slot_q[k];
            if (wr_sel[k] && slot_q[k].valid) begin
                slot_w[k].ready = 1'b1;
                slot_w[k].data  = FPU_WIDTH'(res_data);
            end
        end
    end

    assign wr_ok        = |(wr_sel & slot_valid);
    assign retire_block = slot_q[LAST].valid & ~slot_q[LAST].ready;
    assign overrun      = adv & slot_w[LAST].valid & ~slot_w[LAST].ready;
    assign wb_valid     = adv & slot_w[LAST].valid & slot_w[LAST].ready;
    assign wb_tag       = TAG_W'(slot_w[LAST].tag);
    assign wb_data      = WIDTH'(slot_w[LAST].data);
    assign err_d        = err_q | overrun | (res_valid & ~wr_ok);
    assign err          = err_q;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_d[k] = slot_w[k];
        end
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_d[k]       = slot_q[k];
                slot_d[k].valid = 1'b0;
                slot_d[k].ready = 1'b0;
            end
        end else if (adv) begin
            for (int k = 1; k < DEPTH; k++) begin
                slot_d[k] = slot_w[k-1];
            end
            slot_d[0].valid = issue_valid;
            slot_d[0].tag   = FPU_TAG_W'(issue_tag);
            slot_d[0].ready = 1'b0;
            slot_d[0].data  = '0;
        end
    end

    // Reset clears control state only; slot tag/data are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k].valid <= 1'b0;
                slot_q[k].ready <= 1'b0;
            end
            err_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            err_q  <= err_d;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fpu_fwd_lookup #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .TAG_W (TAG_W)
        ) u_lookup (
            .rd_tag     (rd_tag[i*TAG_W +: TAG_W]),
            .rf_data    (rf_data[i*WIDTH +: WIDTH]),
            .slot_valid (slot_valid),
            .slot_ready (slot_ready),
            .slot_tag   (slot_tag),
            .slot_data  (slot_data),
            .src_data   (src_data[i*WIDTH +: WIDTH]),
            .src_fwd    (src_fwd[i]),
            .pending    (pend[i])
        );
    end

    assign hazard = |pend;

`ifdef FPU_FWD_HAZARD_CNT_EN
    logic [31:0] hcnt_q, hcnt_d;

    assign hcnt_d = (hazard && (hcnt_q != '1)) ? hcnt_q + 32'd1 : hcnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end

    assign hazard_cnt = hcnt_q;
`endif

endmodule

// File: tb/tb_fpu_fwd_scoreboard.sv
// Self-checking bench for fpu_fwd_scoreboard: directed literal cases followed by
// randomized traffic compared every cycle against a behavioural slot model.
module tb_fpu_fwd_scoreboard;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int NSRC   = 3;
    localparam int TAG_W  = 5;
    localparam int SLOT_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n, adv, flush, issue_valid, res_valid;
    logic [TAG_W-1:0]      issue_tag;
    logic [SLOT_W-1:0]     res_slot;
    logic [WIDTH-1:0]      res_data;
    logic [NSRC*TAG_W-1:0] rd_tag;
    logic [NSRC*WIDTH-1:0] rf_data;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_fwd;
    logic                  hazard, retire_block, wb_valid, err;
    logic [TAG_W-1:0]      wb_tag;
    logic [WIDTH-1:0]      wb_data;
`ifdef FPU_FWD_HAZARD_CNT_EN
    logic [31:0]           hazard_cnt;
    logic [31:0]           mcnt;
`endif

    always #5 clk = ~clk;

    fpu_fwd_scoreboard #(
        .WIDTH (WIDTH), .DEPTH (DEPTH), .NSRC (NSRC), .TAG_W (TAG_W), .SLOT_W (SLOT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adv          (adv),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_tag    (issue_tag),
        .res_valid    (res_valid),
        .res_slot     (res_slot),
        .res_data     (res_data),
        .rd_tag       (rd_tag),
        .rf_data      (rf_data),
        .src_data     (src_data),
        .src_fwd      (src_fwd),
        .hazard       (hazard),
        .retire_block (retire_block),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .err          (err)
`ifdef FPU_FWD_HAZARD_CNT_EN
        ,
        .hazard_cnt   (hazard_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: slot 0 youngest, slot DEPTH-1 oldest.
    bit               mv [DEPTH];
    bit               mr [DEPTH];
    logic [TAG_W-1:0] mt [DEPTH];
    logic [WIDTH-1:0] md [DEPTH];
    bit               merr  = 1'b0;
    bit               armed = 1'b0;

    function automatic void lookup(input int i, output logic [WIDTH-1:0] d,
                                   output bit f, output bit p);
        logic [TAG_W-1:0] t;
        t = rd_tag[i*TAG_W +: TAG_W];
        d = rf_data[i*WIDTH +: WIDTH];
        f = 1'b0;
        p = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (mv[k] && mt[k] == t) begin
                if (mr[k]) begin
                    d = md[k];
                    f = 1'b1;
                end else begin
                    p = 1'b1;
                end
                break;
            end
        end
    endfunction

    function automatic bit exp_hazard();
        logic [WIDTH-1:0] d;
        bit f, p, h;
        h = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            lookup(i, d, f, p);
            h |= p;
        end
        return h;
    endfunction

    function automatic bit last_written();
        return res_valid && (int'(res_slot) == DEPTH - 1) && mv[DEPTH-1];
    endfunction

    task automatic model_step();
        bit w3, hz;
        hz = exp_hazard();
        w3 = last_written();
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mv[k] = 1'b0;
                mr[k] = 1'b0;
            end
            merr  = 1'b0;
            armed = 1'b1;
`ifdef FPU_FWD_HAZARD_CNT_EN
            mcnt = 32'd0;
`endif
        end else begin
`ifdef FPU_FWD_HAZARD_CNT_EN
            if (hz && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
`endif
            if (res_valid && !mv[res_slot]) merr = 1'b1;
            if (adv && mv[DEPTH-1] && !mr[DEPTH-1] && !w3) merr = 1'b1;
            if (res_valid && mv[res_slot]) begin
                mr[res_slot] = 1'b1;
                md[res_slot] = res_data;
            end
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mv[k] = 1'b0;
                    mr[k] = 1'b0;
                end
            end else if (adv) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    mv[k] = mv[k-1];
                    mr[k] = mr[k-1];
                    mt[k] = mt[k-1];
                    md[k] = md[k-1];
                end
                mv[0] = issue_valid;
                mt[0] = issue_tag;
                mr[0] = 1'b0;
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        logic [WIDTH-1:0] d;
        bit f, p, wv;
        if (armed) begin
            for (int i = 0; i < NSRC; i++) begin
                lookup(i, d, f, p);
                chk($sformatf("src_data%0d", i), src_data[i*WIDTH +: WIDTH], d);
                chk($sformatf("src_fwd%0d", i), src_fwd[i], f);
            end
            chk("hazard", hazard, exp_hazard());
            chk("retire_block", retire_block, mv[DEPTH-1] && !mr[DEPTH-1]);
            wv = adv && mv[DEPTH-1] && (mr[DEPTH-1] || last_written());
            chk("wb_valid", wb_valid, wv);
            if (wv) begin
                chk("wb_tag", wb_tag, mt[DEPTH-1]);
                chk("wb_data", wb_data, last_written() ? res_data : md[DEPTH-1]);
            end
            chk("err", err, merr);
`ifdef FPU_FWD_HAZARD_CNT_EN
            chk("hazard_cnt", hazard_cnt, mcnt);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        adv         = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = '0;
        res_valid   = 1'b0;
        res_slot    = '0;
        res_data    = '0;
        rd_tag      = {NSRC{5'h1F}};
        for (int i = 0; i < NSRC; i++) rf_data[i*WIDTH +: WIDTH] = 32'h0000_1000 + i;
    endtask

    task automatic set_rd(input int i, input logic [TAG_W-1:0] t);
        rd_tag[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic set_rf(input int i, input logic [WIDTH-1:0] v);
        rf_data[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        int vcnt;
        int vlist [DEPTH];
        bit blocked;

        rst_n = 1'b0;
        set_idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state: miss returns the register-file value.
        set_idle(); set_rd(0, 3); set_rf(0, 32'hAAAA_0000);
        #1;
        chk("rst_src_data", src_data[WIDTH-1:0], 32'hAAAA_0000);
        chk("rst_src_fwd", src_fwd, 3'b000);
        chk("rst_hazard", hazard, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_retire_block", retire_block, 1'b0);
        chk("rst_err", err, 1'b0);
        tick();

        // Issue tag 3, then a pending match, then the result is forwarded.
        set_idle(); adv = 1'b1; issue_valid = 1'b1; issue_tag = 5'd3;
        tick();
        set_idle(); set_rd(0, 3); set_rf(0, 32'hAAAA_0000);
        res_valid = 1'b1; res_slot = 2'd0; res_data = 32'h3F80_0000;
        #1;
        chk("pend_hazard", hazard, 1'b1);
        chk("pend_src_fwd", src_fwd[0], 1'b0);
        tick();
        set_idle(); set_rd(0, 3);
        #1;
        chk("fwd_src_data", src_data[WIDTH-1:0], 32'h3F80_0000);
        chk("fwd_src_fwd", src_fwd[0], 1'b1);
        chk("fwd_hazard", hazard, 1'b0);
        tick();

        // Build tag 7 ready in slot 2 (0x11) and tag 7 ready in slot 0 (0x22).
        set_idle(); adv = 1'b1; issue_valid = 1'b1; issue_tag = 5'd7;
        tick();
        set_idle(); adv = 1'b1; res_valid = 1'b1; res_slot = 2'd0; res_data = 32'h11;
        tick();
        set_idle(); adv = 1'b1; issue_valid = 1'b1; issue_tag = 5'd7;
        tick();
        set_idle(); res_valid = 1'b1; res_slot = 2'd0; res_data = 32'h22;
        tick();
        set_idle(); set_rd(0, 7);
        #1;
        chk("youngest_src_data", src_data[WIDTH-1:0], 32'h22);
        chk("youngest_hazard", hazard, 1'b0);
        tick();
        set_idle(); adv = 1'b1; issue_valid = 1'b1; issue_tag = 5'd7;
        #1;
        chk("retire3_wb_valid", wb_valid, 1'b1);
        chk("retire3_wb_tag", wb_tag, 5'd3);
        chk("retire3_wb_data", wb_data, 32'h3F80_0000);
        tick();
        set_idle(); set_rd(0, 7); set_rf(0, 32'hBEEF);
        #1;
        chk("young_pending_hazard", hazard, 1'b1);
        chk("young_pending_src", src_data[WIDTH-1:0], 32'hBEEF);
        tick();

        // Flush empties everything.
        set_idle(); flush = 1'b1;
        tick();
        set_idle(); set_rd(0, 7);
        #1;
        chk("flush_src_fwd", src_fwd[0], 1'b0);
        chk("flush_hazard", hazard, 1'b0);
        tick();

        // Oldest entry not ready blocks retire; same-cycle write releases it.
        set_idle(); adv = 1'b1; issue_valid = 1'b1; issue_tag = 5'd9;
        tick();
        repeat (3) begin set_idle(); adv = 1'b1; tick(); end
        set_idle();
        #1;
        chk("retire_block_set", retire_block, 1'b1);
        tick();
        set_idle(); adv = 1'b1; res_valid = 1'b1; res_slot = 2'd3; res_data = 32'h55;
        #1;
        chk("bypass_wb_valid", wb_valid, 1'b1);
        chk("bypass_wb_data", wb_data, 32'h55);
        chk("bypass_wb_tag", wb_tag, 5'd9);
        tick();
        set_idle();
        #1;
        chk("bypass_err", err, 1'b0);
        tick();

        // Advancing over a blocked entry is a sticky error.
        set_idle(); adv = 1'b1; issue_valid = 1'b1; issue_tag = 5'd10;
        tick();
        repeat (3) begin set_idle(); adv = 1'b1; tick(); end
        set_idle(); adv = 1'b1;
        #1;
        chk("overrun_block", retire_block, 1'b1);
        chk("overrun_wb_valid", wb_valid, 1'b0);
        tick();
        repeat (3) begin set_idle(); tick(); end
        set_idle();
        #1;
        chk("overrun_err_sticky", err, 1'b1);
        chk("overrun_dropped", retire_block, 1'b0);
        tick();
        rst_n = 1'b0; set_idle();
        tick();
        rst_n = 1'b1; set_idle();
        #1;
        chk("err_cleared", err, 1'b0);
        tick();

        // Write to an invalid slot.
        set_idle(); res_valid = 1'b1; res_slot = 2'd1; res_data = 32'h77;
        tick();
        set_idle();
        #1;
        chk("bad_write_err", err, 1'b1);
        tick();

        // Flush beats a simultaneous issue and advance.
        set_idle(); adv = 1'b1; issue_valid = 1'b1; issue_tag = 5'd12;
        tick();
        set_idle(); flush = 1'b1; adv = 1'b1; issue_valid = 1'b1; issue_tag = 5'd12;
        tick();
        set_idle(); set_rd(0, 12); set_rd(1, 12);
        #1;
        chk("flush_issue_fwd", src_fwd, 3'b000);
        chk("flush_issue_hazard", hazard, 1'b0);
        tick();

        // Five hazard cycles from a clean reset.
        rst_n = 1'b0; set_idle();
        tick();
        rst_n = 1'b1;
        set_idle(); adv = 1'b1; issue_valid = 1'b1; issue_tag = 5'd5;
        tick();
        repeat (5) begin set_idle(); set_rd(0, 5); tick(); end
        set_idle();
        #1;
`ifdef FPU_FWD_HAZARD_CNT_EN
        chk("hazard_cnt_5", hazard_cnt, 32'd5);
`endif
        chk("hazard_cnt_idle", hazard, 1'b0);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            rst_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < NSRC; i++) begin
                set_rd(i, TAG_W'($urandom_range(0, 7)));
                set_rf(i, $urandom);
            end
            issue_valid = $urandom_range(0, 1);
            issue_tag   = TAG_W'($urandom_range(0, 7));
            res_valid   = $urandom_range(0, 1);
            res_data    = $urandom;
            vcnt = 0;
            for (int k = 0; k < DEPTH; k++) if (mv[k]) begin vlist[vcnt] = k; vcnt++; end
            if (vcnt > 0 && $urandom_range(0, 3) != 0)
                res_slot = SLOT_W'(vlist[$urandom_range(0, vcnt - 1)]);
            else
                res_slot = SLOT_W'($urandom_range(0, DEPTH - 1));
            flush   = ($urandom_range(0, 29) == 0);
            blocked = mv[DEPTH-1] && !mr[DEPTH-1] && !last_written();
            adv     = blocked ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
